// File: rtl/frame_uart_streamer.sv
// Streams a frame of RAM bytes to a UART transmitter on each rising VS edge.
// Optional two-byte frame header is enabled by defining FRAME_STREAM_HEADER_EN.
module frame_uart_streamer #(
  parameter int unsigned BYTES_PER_FRAME = 9216,
  parameter int unsigned ADDR_W          = 15,
  parameter int unsigned GAP_CLKS        = 16275,
  parameter logic [7:0]  HDR0            = 8'hAA,
  parameter logic [7:0]  HDR1            = 8'h55
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic              i_VS,
  output logic              o_Rd_En,
  output logic [ADDR_W-1:0] o_Rd_Addr,
  input  logic [7:0]        i_Rd_Data,
  output logic              o_Tx_Valid,
  output logic [7:0]        o_Tx_Byte,
  input  logic              i_Tx_Ready,
  output logic              o_Busy,
  output logic              o_Frame_Done,
  output logic [15:0]       o_Frame_Cnt,
  output logic [7:0]        o_Drop_Cnt
);

  localparam int unsigned   CntW    = ADDR_W + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(BYTES_PER_FRAME);
  localparam int unsigned   GapW    = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
  localparam logic [GapW-1:0] GapLoad = GapW'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);

`ifdef FRAME_STREAM_HEADER_EN
  typedef enum logic [2:0] {
    StIdle, StHdr0, StHdr1, StFetch, StLoad, StSend, StGap, StDone
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle, StFetch, StLoad, StSend, StGap, StDone
  } state_e;
`endif

  state_e            state_q, state_d;
  logic              vs_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic [7:0]        byte_q, byte_d;
  logic              rd_en_q, rd_en_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;
  logic              vs_edge;
  logic              accept;
  logic              last_byte;

`ifdef FRAME_STREAM_HEADER_EN
  state_e            ret_q, ret_d;
`else
  logic              unused_hdr;
  assign unused_hdr = ^{HDR0, HDR1};
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    byte_d      = byte_q;
    rd_en_d     = 1'b0;
    valid_d     = valid_q;
    done_d      = 1'b0;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
`ifdef FRAME_STREAM_HEADER_EN
    ret_d       = ret_q;
`endif

    vs_edge   = i_VS & ~vs_q;
    accept    = valid_q & i_Tx_Ready;
    last_byte = (cnt_q + 1'b1) == LastCnt;

    // Edges outside IDLE are dropped, including one coinciding with DONE.
    if (vs_edge && (state_q != StIdle) && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (vs_edge) begin
          cnt_d  = '0;
          addr_d = '0;
`ifdef FRAME_STREAM_HEADER_EN
          state_d = StHdr0;
          byte_d  = HDR0;
          valid_d = 1'b1;
`else
          state_d = StFetch;
          rd_en_d = 1'b1;
`endif
        end
      end
`ifdef FRAME_STREAM_HEADER_EN
      StHdr0: begin
        if (accept) begin
          if (GAP_CLKS == 0) begin
            state_d = StHdr1;
            byte_d  = HDR1;
          end else begin
            state_d = StGap;
            gap_d   = GapLoad;
            ret_d   = StHdr1;
            valid_d = 1'b0;
          end
        end
      end
      StHdr1: begin
        if (accept) begin
          valid_d = 1'b0;
          if (GAP_CLKS == 0) begin
            state_d = StFetch;
            rd_en_d = 1'b1;
          end else begin
            state_d = StGap;
            gap_d   = GapLoad;
            ret_d   = StFetch;
          end
        end
      end
`endif
      StFetch: state_d = StLoad;
      StLoad: begin
        byte_d  = i_Rd_Data;
        valid_d = 1'b1;
        state_d = StSend;
      end
      StSend: begin
        if (accept) begin
          valid_d = 1'b0;
          cnt_d   = cnt_q + 1'b1;
          addr_d  = last_byte ? '0 : addr_q + 1'b1;
          if (last_byte) begin
            state_d     = StDone;
            done_d      = 1'b1;
            frame_cnt_d = frame_cnt_q + 16'd1;
          end else if (GAP_CLKS == 0) begin
            state_d = StFetch;
            rd_en_d = 1'b1;
          end else begin
            state_d = StGap;
            gap_d   = GapLoad;
`ifdef FRAME_STREAM_HEADER_EN
            ret_d   = StFetch;
`endif
          end
        end
      end
      StGap: begin
        if (gap_q == '0) begin
`ifdef FRAME_STREAM_HEADER_EN
          if (ret_q == StHdr1) begin
            state_d = StHdr1;
            byte_d  = HDR1;
            valid_d = 1'b1;
          end else begin
            state_d = StFetch;
            rd_en_d = 1'b1;
          end
`else
          state_d = StFetch;
          rd_en_d = 1'b1;
`endif
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q     <= StIdle;
      vs_q        <= 1'b1;
      addr_q      <= '0;
      cnt_q       <= '0;
      gap_q       <= '0;
      byte_q      <= 8'h00;
      rd_en_q     <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= 16'h0000;
      drop_cnt_q  <= 8'h00;
`ifdef FRAME_STREAM_HEADER_EN
      ret_q       <= StFetch;
`endif
    end else begin
      state_q     <= state_d;
      vs_q        <= i_VS;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      byte_q      <= byte_d;
      rd_en_q     <= rd_en_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
`ifdef FRAME_STREAM_HEADER_EN
      ret_q       <= ret_d;
`endif
    end
  end

  assign o_Rd_En      = rd_en_q;
  assign o_Rd_Addr    = addr_q;
  assign o_Tx_Valid   = valid_q;
  assign o_Tx_Byte    = byte_q;
  assign o_Busy       = busy_q;
  assign o_Frame_Done = done_q;
  assign o_Frame_Cnt  = frame_cnt_q;
  assign o_Drop_Cnt   = drop_cnt_q;

endmodule

// File: tb/tb_frame_uart_streamer.sv
// Scoreboard bench for frame_uart_streamer: dut_a has no gap, dut_b has a 3-clock gap.
// Honours FRAME_STREAM_HEADER_EN when the design is built with the header.
module tb_frame_uart_streamer;

  localparam int unsigned Bpf = 4;
  localparam int unsigned Aw  = 3;
`ifdef FRAME_STREAM_HEADER_EN
  localparam int HdrN = 2;
`else
  localparam int HdrN = 0;
`endif

  typedef struct {
    logic [7:0] data;
    int         t;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [7:0] pix [4];

  logic          vs_a, rd_en_a, tx_valid_a, ready_a, busy_a, done_a;
  logic [Aw-1:0] rd_addr_a;
  logic [7:0]    rd_data_a, tx_byte_a, drop_a;
  logic [15:0]   fcnt_a;
  logic          vs_b, rd_en_b, tx_valid_b, ready_b, busy_b, done_b;
  logic [Aw-1:0] rd_addr_b;
  logic [7:0]    rd_data_b, tx_byte_b, drop_b;
  logic [15:0]   fcnt_b;

  exp_t qa[$];
  exp_t qb[$];
  int   acc_a = 0;
  int   b_idx = 0;
  int   b_last = 0;

  frame_uart_streamer #(
    .BYTES_PER_FRAME(Bpf), .ADDR_W(Aw), .GAP_CLKS(0)
  ) dut_a (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_VS(vs_a), .o_Rd_En(rd_en_a), .o_Rd_Addr(rd_addr_a),
    .i_Rd_Data(rd_data_a), .o_Tx_Valid(tx_valid_a), .o_Tx_Byte(tx_byte_a),
    .i_Tx_Ready(ready_a), .o_Busy(busy_a), .o_Frame_Done(done_a), .o_Frame_Cnt(fcnt_a),
    .o_Drop_Cnt(drop_a)
  );

  frame_uart_streamer #(
    .BYTES_PER_FRAME(Bpf), .ADDR_W(Aw), .GAP_CLKS(3)
  ) dut_b (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_VS(vs_b), .o_Rd_En(rd_en_b), .o_Rd_Addr(rd_addr_b),
    .i_Rd_Data(rd_data_b), .o_Tx_Valid(tx_valid_b), .o_Tx_Byte(tx_byte_b),
    .i_Tx_Ready(ready_b), .o_Busy(busy_b), .o_Frame_Done(done_b), .o_Frame_Cnt(fcnt_b),
    .o_Drop_Cnt(drop_b)
  );

  // Synchronous-read RAM models: data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (rd_en_a) rd_data_a <= (rd_addr_a < 3'd4) ? pix[rd_addr_a[1:0]] : 8'h00;
    if (rd_en_b) rd_data_b <= (rd_addr_b < 3'd4) ? pix[rd_addr_b[1:0]] : 8'h00;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm, input int act, input int exp);
    checks++;
    errors++;
    $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // n < 0: byte order is checked but not acceptance cycles.
  task automatic push_frame(input bit sel_b, input int n);
    exp_t e;
    if (HdrN == 2) begin
      e.data = 8'hAA; e.t = (n < 0 || sel_b) ? -1 : n + 1;
      if (sel_b) qb.push_back(e); else qa.push_back(e);
      e.data = 8'h55; e.t = (n < 0 || sel_b) ? -1 : n + 2;
      if (sel_b) qb.push_back(e); else qa.push_back(e);
    end
    for (int i = 0; i < 4; i++) begin
      e.data = pix[i];
      e.t    = (n < 0 || sel_b) ? -1 : n + 3 + HdrN + 3 * i;
      if (sel_b) qb.push_back(e); else qa.push_back(e);
    end
  endtask

  task automatic wait_done(input bit sel_b, input int exp_c, input string nm);
    bit seen = 1'b0;
    for (int n = 0; n < 1000 && !seen; n++) begin
      @(negedge clk);
      if (sel_b ? done_b : done_a) seen = 1'b1;
    end
    if (!seen) begin
      fail({nm, "_done_timeout"}, 0, 1);
    end else begin
      if (exp_c >= 0) chk({nm, "_done_cycle"}, cyc + 1, exp_c);
      @(negedge clk);
      chk({nm, "_done_width"}, int'(sel_b ? done_b : done_a), 0);
      chk({nm, "_busy_after"}, int'(sel_b ? busy_b : busy_a), 0);
    end
  endtask

  task automatic wait_acc(input int target, input string nm);
    int n = 0;
    while (acc_a < target && n < 500) begin
      tick(1);
      n++;
    end
    if (acc_a < target) fail({nm, "_accept_timeout"}, acc_a, target);
  endtask

  // Monitor A: scoreboard pop on acceptance plus hold-while-stalled checks.
  logic       pv_a = 1'b0, pacc_a = 1'b0;
  logic [7:0] pbyte_a = 8'h00;
  always @(negedge clk) begin
    exp_t e;
    logic acc;
    if (!rst_n) begin
      pv_a   = 1'b0;
      pacc_a = 1'b0;
    end else begin
      if (pv_a && !pacc_a) begin
        chk("hold_valid", int'(tx_valid_a), 1);
        chk("hold_byte", int'(tx_byte_a), int'(pbyte_a));
      end
      acc = tx_valid_a && ready_a;
      if (acc) begin
        acc_a++;
        if (qa.size() == 0) begin
          fail("unexpected_byte_a", int'(tx_byte_a), 0);
        end else begin
          e = qa.pop_front();
          chk("byte_a", int'(tx_byte_a), int'(e.data));
          if (e.t >= 0) chk("accept_cycle_a", cyc + 1, e.t);
        end
      end
      pv_a    = tx_valid_a;
      pacc_a  = acc;
      pbyte_a = tx_byte_a;
    end
  end

  // Monitor B: byte order and data-to-data spacing with the gap.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && tx_valid_b && ready_b) begin
      if (qb.size() == 0) begin
        fail("unexpected_byte_b", int'(tx_byte_b), 0);
      end else begin
        e = qb.pop_front();
        chk("byte_b", int'(tx_byte_b), int'(e.data));
      end
      if (b_idx >= HdrN + 1) chk("gap_spacing_b", cyc + 1 - b_last, 6);
      b_last = cyc + 1;
      b_idx++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    pix[0] = 8'h11; pix[1] = 8'h22; pix[2] = 8'h33; pix[3] = 8'h44;
    rst_n = 1'b0; vs_a = 1'b0; vs_b = 1'b0; ready_a = 1'b1; ready_b = 1'b1;
    rd_data_a = 8'h00; rd_data_b = 8'h00;

    tick(2);
    chk("rst_rd_en", int'(rd_en_a), 0);
    chk("rst_tx_valid", int'(tx_valid_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_frame_cnt", int'(fcnt_a), 0);
    chk("rst_drop_cnt", int'(drop_a), 0);
    rst_n = 1'b1;
    tick(2);

    // Basic frame, ready high, no gap.
    vs_a = 1'b1;
    n = cyc + 1;
    push_frame(1'b0, n);
    tick(1);
    vs_a = 1'b0;
    wait_done(1'b0, n + 13 + HdrN, "frame1");
    chk("frame1_cnt", int'(fcnt_a), 1);
    chk("frame1_queue_empty", qa.size(), 0);

    // Gap of 3 clocks on dut_b.
    tick(1);
    vs_b = 1'b1;
    push_frame(1'b1, -1);
    tick(1);
    vs_b = 1'b0;
    wait_done(1'b1, -1, "gap");
    chk("gap_byte_count", b_idx, 4 + HdrN);
    chk("gap_frame_cnt", int'(fcnt_b), 1);

    // Ready stalled during byte 2.
    tick(1);
    base = acc_a;
    vs_a = 1'b1;
    push_frame(1'b0, -1);
    tick(1);
    vs_a = 1'b0;
    wait_acc(base + 1 + HdrN, "stall");
    ready_a = 1'b0;
    tick(10);
    ready_a = 1'b1;
    wait_done(1'b0, -1, "stall");
    chk("stall_byte_count", acc_a - base, 4 + HdrN);
    chk("stall_frame_cnt", int'(fcnt_a), 2);

    // Repeated VS edges mid-frame saturate the drop counter.
    tick(1);
    base = acc_a;
    ready_a = 1'b0;
    vs_a = 1'b1;
    push_frame(1'b0, -1);
    tick(1);
    vs_a = 1'b0;
    tick(1);
    for (int i = 0; i < 301; i++) begin
      vs_a = 1'b1;
      tick(1);
      vs_a = 1'b0;
      tick(1);
    end
    ready_a = 1'b1;
    wait_done(1'b0, -1, "drop");
    chk("drop_cnt_sat", int'(drop_a), 255);
    chk("drop_frame_cnt", int'(fcnt_a), 3);
    chk("drop_byte_count", acc_a - base, 4 + HdrN);

    // Reset during byte 3 with VS held high.
    tick(1);
    base = acc_a;
    vs_a = 1'b1;
    push_frame(1'b0, -1);
    wait_acc(base + 2 + HdrN, "reset");
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rd_en", int'(rd_en_a), 0);
    chk("mid_rst_rd_addr", int'(rd_addr_a), 0);
    chk("mid_rst_tx_valid", int'(tx_valid_a), 0);
    chk("mid_rst_tx_byte", int'(tx_byte_a), 0);
    chk("mid_rst_busy", int'(busy_a), 0);
    chk("mid_rst_done", int'(done_a), 0);
    chk("mid_rst_frame_cnt", int'(fcnt_a), 0);
    chk("mid_rst_drop_cnt", int'(drop_a), 0);
    tick(2);
    rst_n = 1'b1;
    qa.delete();
    base = acc_a;
    tick(20);
    chk("post_rst_nothing_sent", acc_a - base, 0);
    chk("post_rst_idle", int'(busy_a), 0);
    vs_a = 1'b0;
    tick(2);
    vs_a = 1'b1;
    n = cyc + 1;
    push_frame(1'b0, n);
    tick(1);
    vs_a = 1'b0;
    wait_done(1'b0, n + 13 + HdrN, "post_rst");
    chk("post_rst_frame_cnt", int'(fcnt_a), 1);
    chk("post_rst_byte_count", acc_a - base, 4 + HdrN);
    chk("post_rst_drop_cnt", int'(drop_a), 0);

    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
